// File: rtl/xosera_pkg.sv
// ============================================================================
//  Module  : xosera_pkg
//  Brief   : Shared types and constants for the VRAM datapath.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package xosera_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [15:0] word_t;

    // Who owns the VRAM cycle currently presented to the macro
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGEN = 2'd1,
        OWN_REGS = 2'd2,
        OWN_BLIT = 2'd3
    } vram_owner_t;

    // Cycles from arbitration to read data / requester ack
    localparam int VRAM_ACK_LAT = 2;

endpackage

`default_nettype wire

// File: rtl/vram_sched.sv
// ============================================================================
//  Module  : vram_sched
//  Brief   : Single-port VRAM scheduler for video, register and blitter ports.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_sched
    import xosera_pkg::*;
#(
    parameter bit EN_BLIT         = 1'b1,
    parameter int BLIT_STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset_n_i,

    input  logic        vgen_sel_i,
    input  logic [15:0] vgen_addr_i,

    input  logic        regs_sel_i,
    input  logic        regs_wr_i,
    input  logic [3:0]  regs_wr_mask_i,
    input  logic [15:0] regs_addr_i,
    input  logic [15:0] regs_data_i,
    output logic        regs_ack_o,

    input  logic        blit_sel_i,
    input  logic        blit_wr_i,
    input  logic [3:0]  blit_wr_mask_i,
    input  logic [15:0] blit_addr_i,
    input  logic [15:0] blit_data_i,
    output logic        blit_ack_o,

    output logic        vram_sel_o,
    output logic        vram_wr_o,
    output logic [3:0]  vram_wr_mask_o,
    output logic [15:0] vram_addr_o,
    output logic [15:0] vram_data_o,
    output logic [1:0]  owner_o
);

    localparam logic [3:0] STARVE_MAX = 4'(BLIT_STARVE_MAX);

    vram_owner_t owner_q;
    vram_owner_t grant_d;
    logic        sel_q;
    logic        sel_d;
    logic        wr_q;
    logic        wr_d;
    logic [3:0]  mask_q;
    logic [3:0]  mask_d;
    addr_t       addr_q;
    addr_t       addr_d;
    word_t       data_q;
    word_t       data_d;
    logic        regs_ack_q;

    logic        regs_elig;
    logic        blit_elig;
    logic        blit_forced;

    // The owner register doubles as the in-flight tag: a requester whose
    // cycle is on the VRAM bus now cannot be granted again until its ack cycle.
    assign regs_elig = regs_sel_i && (owner_q != OWN_REGS);

    always_comb begin
        grant_d = OWN_NONE;
        if (vgen_sel_i) begin
            grant_d = OWN_VGEN;
        end else if (blit_elig && blit_forced) begin
            grant_d = OWN_BLIT;
        end else if (regs_elig) begin
            grant_d = OWN_REGS;
        end else if (blit_elig) begin
            grant_d = OWN_BLIT;
        end
    end

    always_comb begin
        sel_d  = 1'b0;
        wr_d   = 1'b0;
        mask_d = 4'h0;
        addr_d = '0;
        data_d = '0;
        case (grant_d)
            OWN_VGEN: begin
                sel_d  = 1'b1;
                addr_d = vgen_addr_i;
            end
            OWN_REGS: begin
                sel_d  = 1'b1;
                wr_d   = regs_wr_i;
                mask_d = regs_wr_mask_i;
                addr_d = regs_addr_i;
                data_d = regs_data_i;
            end
            OWN_BLIT: begin
                sel_d  = 1'b1;
                wr_d   = blit_wr_i;
                mask_d = blit_wr_mask_i;
                addr_d = blit_addr_i;
                data_d = blit_data_i;
            end
            default: begin
                sel_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            owner_q    <= OWN_NONE;
            sel_q      <= 1'b0;
            wr_q       <= 1'b0;
            mask_q     <= 4'h0;
            addr_q     <= '0;
            data_q     <= '0;
            regs_ack_q <= 1'b0;
        end else begin
            owner_q    <= grant_d;
            sel_q      <= sel_d;
            wr_q       <= wr_d;
            mask_q     <= mask_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            regs_ack_q <= (owner_q == OWN_REGS);
        end
    end

    generate
        if (EN_BLIT) begin : g_blit
            logic [3:0] starve_q;
            logic [3:0] starve_d;
            logic       blit_ack_q;

            assign blit_elig   = blit_sel_i && (owner_q != OWN_BLIT);
            assign blit_forced = (starve_q == STARVE_MAX);

            // Only a loss to regs counts; cycles taken by vgen leave the count alone
            always_comb begin
                starve_d = starve_q;
                if (!blit_sel_i || (grant_d == OWN_BLIT)) begin
                    starve_d = 4'd0;
                end else if ((grant_d == OWN_REGS) && blit_elig && (starve_q != STARVE_MAX)) begin
                    starve_d = starve_q + 4'd1;
                end
            end

            always_ff @(posedge clk or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    starve_q   <= 4'd0;
                    blit_ack_q <= 1'b0;
                end else begin
                    starve_q   <= starve_d;
                    blit_ack_q <= (owner_q == OWN_BLIT);
                end
            end

            assign blit_ack_o = blit_ack_q;
        end else begin : g_no_blit
            logic unused_blit;

            assign unused_blit = blit_sel_i;
            assign blit_elig   = 1'b0;
            assign blit_forced = 1'b0;
            assign blit_ack_o  = 1'b0;
        end
    endgenerate

    assign regs_ack_o     = regs_ack_q;
    assign vram_sel_o     = sel_q;
    assign vram_wr_o      = wr_q;
    assign vram_wr_mask_o = mask_q;
    assign vram_addr_o    = addr_q;
    assign vram_data_o    = data_q;
    assign owner_o        = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_sched.sv
// ============================================================================
//  Module  : tb_vram_sched
//  Brief   : Directed scoreboard bench for the VRAM scheduler.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_sched;
    import xosera_pkg::*;

    typedef struct packed {
        logic [1:0]  own;
        logic        wr;
        logic [3:0]  mask;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n_i;
    logic        vgen_sel_i;
    logic [15:0] vgen_addr_i;
    logic        regs_sel_i, regs_wr_i;
    logic [3:0]  regs_wr_mask_i;
    logic [15:0] regs_addr_i, regs_data_i;
    logic        blit_sel_i, blit_wr_i;
    logic [3:0]  blit_wr_mask_i;
    logic [15:0] blit_addr_i, blit_data_i;
    logic        nb_blit_sel_i;

    logic        regs_ack_o, blit_ack_o, vram_sel_o, vram_wr_o;
    logic [3:0]  vram_wr_mask_o;
    logic [15:0] vram_addr_o, vram_data_o;
    logic [1:0]  owner_o;

    logic        nb_regs_ack_o, nb_blit_ack_o, nb_vram_sel_o, nb_vram_wr_o;
    logic [3:0]  nb_vram_wr_mask_o;
    logic [15:0] nb_vram_addr_o, nb_vram_data_o;
    logic [1:0]  nb_owner_o;

    vram_sched #(.EN_BLIT(1'b1), .BLIT_STARVE_MAX(4)) dut (
        .clk(clk), .reset_n_i(reset_n_i),
        .vgen_sel_i(vgen_sel_i), .vgen_addr_i(vgen_addr_i),
        .regs_sel_i(regs_sel_i), .regs_wr_i(regs_wr_i), .regs_wr_mask_i(regs_wr_mask_i),
        .regs_addr_i(regs_addr_i), .regs_data_i(regs_data_i), .regs_ack_o(regs_ack_o),
        .blit_sel_i(blit_sel_i), .blit_wr_i(blit_wr_i), .blit_wr_mask_i(blit_wr_mask_i),
        .blit_addr_i(blit_addr_i), .blit_data_i(blit_data_i), .blit_ack_o(blit_ack_o),
        .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_wr_mask_o(vram_wr_mask_o),
        .vram_addr_o(vram_addr_o), .vram_data_o(vram_data_o), .owner_o(owner_o)
    );

    vram_sched #(.EN_BLIT(1'b0), .BLIT_STARVE_MAX(4)) dut_nb (
        .clk(clk), .reset_n_i(reset_n_i),
        .vgen_sel_i(vgen_sel_i), .vgen_addr_i(vgen_addr_i),
        .regs_sel_i(regs_sel_i), .regs_wr_i(regs_wr_i), .regs_wr_mask_i(regs_wr_mask_i),
        .regs_addr_i(regs_addr_i), .regs_data_i(regs_data_i), .regs_ack_o(nb_regs_ack_o),
        .blit_sel_i(nb_blit_sel_i), .blit_wr_i(blit_wr_i), .blit_wr_mask_i(blit_wr_mask_i),
        .blit_addr_i(blit_addr_i), .blit_data_i(blit_data_i), .blit_ack_o(nb_blit_ack_o),
        .vram_sel_o(nb_vram_sel_o), .vram_wr_o(nb_vram_wr_o), .vram_wr_mask_o(nb_vram_wr_mask_o),
        .vram_addr_o(nb_vram_addr_o), .vram_data_o(nb_vram_data_o), .owner_o(nb_owner_o)
    );

    int          checks;
    int          failures;
    txn_t        exp_q[$];
    logic        exp_ack_r, exp_ack_b;
    logic        hold;
    logic [15:0] rd_next, rdata;
    logic [15:0] mem [0:65535];
    logic [9:0]  vpat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input vram_owner_t own, input logic wr, input logic [3:0] mask,
                        input logic [15:0] addr, input logic [15:0] data);
        txn_t t;
        t.own  = own;
        t.wr   = wr;
        t.mask = mask;
        t.addr = addr;
        t.data = data;
        exp_q.push_back(t);
    endtask

    // One clock: sample outputs, score the VRAM cycle, model the macro, track acks
    task automatic step();
        txn_t t;
        logic has_t;
        @(posedge clk);
        #1;
        rdata = rd_next;
        chk("regs_ack", 32'(regs_ack_o), 32'(exp_ack_r));
        chk("blit_ack", 32'(blit_ack_o), 32'(exp_ack_b));
        exp_ack_r = 1'b0;
        exp_ack_b = 1'b0;
        if (vram_sel_o) begin
            has_t = (exp_q.size() != 0);
            checks++;
            assert (has_t) else begin
                failures++;
                $error("FAIL unexpected_cycle observed owner=%0d addr=%0h expected none", owner_o, vram_addr_o);
            end
            if (has_t) begin
                t = exp_q.pop_front();
                chk("sb_owner", 32'(owner_o), 32'(t.own));
                chk("sb_wr", 32'(vram_wr_o), 32'(t.wr));
                chk("sb_mask", 32'(vram_wr_mask_o), 32'(t.mask));
                chk("sb_addr", 32'(vram_addr_o), 32'(t.addr));
                chk("sb_data", 32'(vram_data_o), 32'(t.data));
                exp_ack_r = (t.own == OWN_REGS);
                exp_ack_b = (t.own == OWN_BLIT);
            end
            if (vram_wr_o) begin
                for (int n = 0; n < 4; n++) begin
                    if (vram_wr_mask_o[n]) mem[vram_addr_o][n*4 +: 4] = vram_data_o[n*4 +: 4];
                end
            end else begin
                rd_next = mem[vram_addr_o];
            end
        end else begin
            chk("idle_owner", 32'(owner_o), 32'(OWN_NONE));
        end
        if (!hold) begin
            if (regs_ack_o) regs_sel_i = 1'b0;
            if (blit_ack_o) blit_sel_i = 1'b0;
        end
    endtask

    initial begin
        checks = 0; failures = 0; hold = 1'b0;
        exp_ack_r = 1'b0; exp_ack_b = 1'b0; rd_next = '0; rdata = '0;
        reset_n_i = 1'b1; vgen_sel_i = 1'b0; vgen_addr_i = '0;
        regs_sel_i = 1'b0; regs_wr_i = 1'b0; regs_wr_mask_i = '0; regs_addr_i = '0; regs_data_i = '0;
        blit_sel_i = 1'b0; blit_wr_i = 1'b0; blit_wr_mask_i = '0; blit_addr_i = '0; blit_data_i = '0;
        nb_blit_sel_i = 1'b0;
        mem[16'h2000] = 16'hBEEF;

        // Reset state
        #2 reset_n_i = 1'b0;
        #1;
        chk("rst_sel", 32'(vram_sel_o), 32'd0);
        chk("rst_wr", 32'(vram_wr_o), 32'd0);
        chk("rst_mask", 32'(vram_wr_mask_o), 32'd0);
        chk("rst_addr", 32'(vram_addr_o), 32'd0);
        chk("rst_data", 32'(vram_data_o), 32'd0);
        chk("rst_owner", 32'(owner_o), 32'(OWN_NONE));
        step(); step();
        reset_n_i = 1'b1;
        step();

        // Single regs write
        regs_sel_i = 1'b1; regs_wr_i = 1'b1; regs_wr_mask_i = 4'hF;
        regs_addr_i = 16'h0100; regs_data_i = 16'h1234;
        push(OWN_REGS, 1'b1, 4'hF, 16'h0100, 16'h1234);
        step();
        chk("t1_wr", 32'(vram_wr_o), 32'd1);
        chk("t1_addr", 32'(vram_addr_o), 32'h0100);
        chk("t1_owner", 32'(owner_o), 32'd2);
        step();
        chk("t1_ack", 32'(regs_ack_o), 32'd1);
        step();
        chk("t1_ack_pulse", 32'(regs_ack_o), 32'd0);

        // vgen holds the bus for 10 cycles while regs waits
        regs_sel_i = 1'b1; regs_wr_i = 1'b0; regs_wr_mask_i = 4'h0;
        regs_addr_i = 16'h0101; regs_data_i = 16'h0000;
        for (int i = 0; i < 10; i++) push(OWN_VGEN, 1'b0, 4'h0, 16'h0A00 + 16'(i), 16'h0000);
        push(OWN_REGS, 1'b0, 4'h0, 16'h0101, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            vgen_sel_i = 1'b1; vgen_addr_i = 16'h0A00 + 16'(i);
            step();
        end
        vgen_sel_i = 1'b0;
        step();
        chk("t4_grant11", 32'(owner_o), 32'(OWN_REGS));
        step();
        chk("t4_ack13", 32'(regs_ack_o), 32'd1);
        step();

        // Blit read returning preloaded data with its ack
        blit_sel_i = 1'b1; blit_wr_i = 1'b0; blit_wr_mask_i = 4'h0;
        blit_addr_i = 16'h2000; blit_data_i = 16'h0000;
        push(OWN_BLIT, 1'b0, 4'h0, 16'h2000, 16'h0000);
        step();
        chk("t5_rd_wr", 32'(vram_wr_o), 32'd0);
        chk("t5_owner", 32'(owner_o), 32'(OWN_BLIT));
        blit_addr_i = 16'h2222;
        step();
        chk("t5_ack", 32'(blit_ack_o), 32'd1);
        chk("t5_rdata", 32'(rdata), 32'hBEEF);
        step();

        // Regs and blit held together interleave R,B,R,B
        hold = 1'b1;
        regs_sel_i = 1'b1; regs_wr_i = 1'b0; regs_wr_mask_i = 4'h0; regs_addr_i = 16'h0300; regs_data_i = 16'h0;
        blit_sel_i = 1'b1; blit_wr_i = 1'b1; blit_wr_mask_i = 4'hF; blit_addr_i = 16'h0400; blit_data_i = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            push(OWN_REGS, 1'b0, 4'h0, 16'h0300, 16'h0000);
            push(OWN_BLIT, 1'b1, 4'hF, 16'h0400, 16'h5555);
        end
        for (int i = 0; i < 10; i++) step();
        regs_sel_i = 1'b0; blit_sel_i = 1'b0; hold = 1'b0;
        step(); step();

        // vgen on alternate cycles lets regs starve blit until the count forces it
        hold = 1'b1;
        regs_addr_i = 16'h0310; blit_addr_i = 16'h0410;
        regs_sel_i = 1'b1; blit_sel_i = 1'b1;
        vpat = 10'b01_1010_1010;
        push(OWN_REGS, 1'b0, 4'h0, 16'h0310, 16'h0000);
        push(OWN_VGEN, 1'b0, 4'h0, 16'h0B01, 16'h0000);
        push(OWN_REGS, 1'b0, 4'h0, 16'h0310, 16'h0000);
        push(OWN_VGEN, 1'b0, 4'h0, 16'h0B03, 16'h0000);
        push(OWN_REGS, 1'b0, 4'h0, 16'h0310, 16'h0000);
        push(OWN_VGEN, 1'b0, 4'h0, 16'h0B05, 16'h0000);
        push(OWN_REGS, 1'b0, 4'h0, 16'h0310, 16'h0000);
        push(OWN_VGEN, 1'b0, 4'h0, 16'h0B07, 16'h0000);
        push(OWN_VGEN, 1'b0, 4'h0, 16'h0B08, 16'h0000);
        push(OWN_BLIT, 1'b1, 4'hF, 16'h0410, 16'h5555);
        for (int i = 0; i < 10; i++) begin
            vgen_sel_i = vpat[i]; vgen_addr_i = 16'h0B00 + 16'(i);
            step();
        end
        chk("t3_forced", 32'(owner_o), 32'(OWN_BLIT));
        vgen_sel_i = 1'b0; regs_sel_i = 1'b0; blit_sel_i = 1'b0; hold = 1'b0;
        step(); step();

        // Reset in the cycle after a regs grant drops the in-flight access
        regs_sel_i = 1'b1; regs_wr_i = 1'b1; regs_wr_mask_i = 4'hF; regs_addr_i = 16'h0600; regs_data_i = 16'h6666;
        push(OWN_REGS, 1'b1, 4'hF, 16'h0600, 16'h6666);
        step();
        chk("t6_grant", 32'(owner_o), 32'(OWN_REGS));
        #1 reset_n_i = 1'b0;
        #1;
        chk("t6_rst_sel", 32'(vram_sel_o), 32'd0);
        chk("t6_rst_owner", 32'(owner_o), 32'(OWN_NONE));
        chk("t6_rst_addr", 32'(vram_addr_o), 32'd0);
        regs_sel_i = 1'b0; exp_ack_r = 1'b0; exp_ack_b = 1'b0;
        step(); step();
        reset_n_i = 1'b1;
        step(); step();
        regs_sel_i = 1'b1; regs_wr_i = 1'b0; regs_wr_mask_i = 4'h0; regs_addr_i = 16'h0100; regs_data_i = 16'h0;
        push(OWN_REGS, 1'b0, 4'h0, 16'h0100, 16'h0000);
        step(); step();
        chk("t6_ack_after", 32'(regs_ack_o), 32'd1);
        chk("t6_rdata", 32'(rdata), 32'h1234);
        step();

        // Blit disabled instance ignores a held blit request
        nb_blit_sel_i = 1'b1; blit_wr_i = 1'b1; blit_wr_mask_i = 4'hF; blit_addr_i = 16'h0700; blit_data_i = 16'h7777;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nb_idle_sel", 32'(nb_vram_sel_o), 32'd0);
            chk("nb_idle_ack", 32'(nb_blit_ack_o), 32'd0);
        end
        regs_sel_i = 1'b1; regs_wr_i = 1'b0; regs_addr_i = 16'h0100;
        push(OWN_REGS, 1'b0, 4'h0, 16'h0100, 16'h0000);
        step();
        chk("nb_regs_owner", 32'(nb_owner_o), 32'(OWN_REGS));
        chk("nb_regs_addr", 32'(nb_vram_addr_o), 32'h0100);
        step();
        chk("nb_regs_ack", 32'(nb_regs_ack_o), 32'd1);
        chk("nb_blit_ack", 32'(nb_blit_ack_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("nb_no_blit_sel", 32'(nb_vram_sel_o), 32'd0);
            chk("nb_no_blit_ack", 32'(nb_blit_ack_o), 32'd0);
        end
        nb_blit_sel_i = 1'b0;

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vram_sched.md
Name: vram_sched

Overview:
- Schedules the single-port VRAM between three requesters: video generation (fixed top priority, no ack), CPU register interface, and blitter.
- Registers one grant per cycle, drives the VRAM macro, and returns a single-cycle ack aligned with read data.
- Regs wins over blit by default; a starvation counter forces a blit grant after BLIT_STARVE_MAX lost cycles, bounding blit latency while vgen is idle.
- Sits between reg_interface/blitter2/video_gen and the VRAM macro.

Parameters:
- EN_BLIT, 1, 0 = blit inputs ignored, blit_ack_o tied 0, starvation logic removed.
- BLIT_STARVE_MAX, 4, consecutive cycles blit may lose arbitration to regs before it is forced (range 1-15).

Ports:
- clk  in  1  pixel clock
- reset_n_i  in  1  asynchronous active-low reset
- vgen_sel_i  in  1  vgen read request (valid this cycle only)
- vgen_addr_i  in  16  vgen address (addr_t)
- regs_sel_i  in  1  regs request, held until regs_ack_o
- regs_wr_i  in  1  1 = write
- regs_wr_mask_i  in  4  nibble write mask
- regs_addr_i  in  16  address
- regs_data_i  in  16  write data
- regs_ack_o  out  1  one-cycle completion pulse
- blit_sel_i, blit_wr_i, blit_wr_mask_i, blit_addr_i, blit_data_i, blit_ack_o  same as regs_*
- vram_sel_o  out  1  VRAM cycle enable
- vram_wr_o  out  1  VRAM write strobe
- vram_wr_mask_o  out  4  nibble mask
- vram_addr_o  out  16  address
- vram_data_o  out  16  write data
- owner_o  out  2  owner of current VRAM cycle (vram_owner_t)

Behaviour:
- Reset (async assert, sync release): all outputs 0; owner_o = OWN_NONE; starve count 0; in-flight tags cleared. Reset mid-operation discards in-flight accesses; no ack is emitted afterwards.
- Cycle N arbitration over eligible requesters; a requester with an un-acked grant in flight is ineligible.
- Priority order:
  - vgen_sel_i always wins.
  - Else blit if blit eligible and starve == BLIT_STARVE_MAX.
  - Else regs if eligible.
  - Else blit if eligible.
  - Else idle (vram_sel_o = 0, owner OWN_NONE).
- Cycle N+1: registered vram_* outputs and owner_o reflect the winner; wr/mask/data are 0 for vgen.
- Cycle N+2: VRAM read data valid; requester ack pulses high for exactly 1 cycle (writes too); in-flight tag clears.
- Requester may drop sel or present a new request in its ack cycle. It is eligible again in that same arbitration cycle, so sustained per-requester rate is 1 per 2 cycles; regs and blit interleave for full bandwidth.
- Starve counter:
  - Increments when blit is eligible but not granted because regs won.
  - Saturates at BLIT_STARVE_MAX.
  - Clears on any blit grant or when blit_sel_i = 0.
  - Holds while vgen wins.
- Simultaneous vgen and forced blit: vgen wins and the counter holds at max; blit wins the next non-vgen cycle.
- Request fields are sampled only in the grant cycle; later changes before ack are ignored.
- sel dropped before grant: the request vanishes with no ack (protocol violation, not an error).

Decomposition:
- xosera_pkg gains typedef vram_owner_t (2-bit enum: OWN_NONE=0, OWN_VGEN=1, OWN_REGS=2, OWN_BLIT=3) and localparam VRAM_ACK_LAT = 2.
- addr_t/word_t reused from the package.
- No sub-module: arbitration, starve counter and 2-stage tag pipeline stay in one file (~200 lines).

Test Plan:
- Regs write 0x1234 @0x0100 mask 0xF, idle otherwise -> vram_wr_o = 1 with addr 0x0100 at N+1; regs_ack_o pulse at N+2; owner_o = 2 at N+1.
- Regs and blit both held continuously, vgen idle, BLIT_STARVE_MAX = 4 -> grants R,B,R,B... and blit latency never exceeds 5 cycles.
- vgen_sel_i high every cycle for 10 cycles with regs pending -> 10 vgen cycles, no regs_ack_o; regs granted on cycle 11, ack at 13.
- Blit read @0x2000 with preloaded 0xBEEF -> vram_wr_o = 0, blit_ack_o at N+2, same cycle as read data 0xBEEF.
- reset_n_i asserted in the cycle after a regs grant -> outputs 0 asynchronously; no regs_ack_o after release; the next request acks normally.
- EN_BLIT = 0 with blit_sel_i = 1 -> blit never granted, blit_ack_o stays 0, regs unaffected.
